// File: rtl/game_flow_ctrl_if.sv
// Command/status bundle between the two requesters, the game state register and the
// status display, as seen by game_flow_ctrl.
// Handshake: *_req is a level valid held with a stable *_func until the matching *_ack
// pulses for one cycle; the requester must drop or change req after that ack cycle.
interface game_flow_ctrl_if;
    logic       btn_req;
    logic [1:0] btn_func;
    logic       uart_req;
    logic [1:0] uart_func;
    logic       btn_ack;
    logic       uart_ack;
    logic       gs_en;
    logic [1:0] gs_func;
    logic       rej;
    logic       running;
    logic       stopped;
    logic [7:0] game_cnt;

    modport master (
        output btn_req, btn_func, uart_req, uart_func,
        input  btn_ack, uart_ack, gs_en, gs_func, rej, running, stopped, game_cnt
    );

    modport slave (
        input  btn_req, btn_func, uart_req, uart_func,
        output btn_ack, uart_ack, gs_en, gs_func, rej, running, stopped, game_cnt
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Arbitrates start/end commands from the button panel and UART decoder, drives the
// game state register command port and enforces a hold-off after every stop.
module game_flow_ctrl #(
    parameter int CNT_W     = 16,
    parameter int STOP_HOLD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    game_flow_ctrl_if.slave   bus,
    output logic [1:0]        dbg_phase_o
);

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_RUN     = 2'd1,
        PH_HOLDOFF = 2'd2,
        PH_STOPPED = 2'd3
    } phase_e;

    localparam logic [1:0]       FUNC_START = 2'b01;
    localparam logic [1:0]       FUNC_END   = 2'b10;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(STOP_HOLD - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             last_uart_q, last_uart_d;
    logic             btn_ack_q, btn_ack_d;
    logic             uart_ack_q, uart_ack_d;
    logic             gs_en_q, gs_en_d;
    logic [1:0]       gs_func_q, gs_func_d;
    logic             rej_q, rej_d;
    logic [7:0]       game_cnt_q, game_cnt_d;

    logic             can_grant;
    logic             gnt_btn;
    logic             gnt_uart;
    logic [1:0]       func;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            hold_q      <= '0;
            last_uart_q <= 1'b1;
            btn_ack_q   <= 1'b0;
            uart_ack_q  <= 1'b0;
            gs_en_q     <= 1'b0;
            gs_func_q   <= 2'b00;
            rej_q       <= 1'b0;
            game_cnt_q  <= 8'd0;
        end else begin
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            last_uart_q <= last_uart_d;
            btn_ack_q   <= btn_ack_d;
            uart_ack_q  <= uart_ack_d;
            gs_en_q     <= gs_en_d;
            gs_func_q   <= gs_func_d;
            rej_q       <= rej_d;
            game_cnt_q  <= game_cnt_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        hold_d      = hold_q;
        last_uart_d = last_uart_q;
        btn_ack_d   = 1'b0;
        uart_ack_d  = 1'b0;
        gs_en_d     = 1'b0;
        gs_func_d   = gs_func_q;
        rej_d       = 1'b0;
        game_cnt_d  = game_cnt_q;

        // An ack-high cycle is a bubble so a still-held req is not consumed twice.
        can_grant = (phase_q != PH_HOLDOFF) && !btn_ack_q && !uart_ack_q;
        gnt_btn   = can_grant && bus.btn_req && (!bus.uart_req || last_uart_q);
        gnt_uart  = can_grant && bus.uart_req && (!bus.btn_req || !last_uart_q);
        func      = gnt_btn ? bus.btn_func : bus.uart_func;

        if (phase_q == PH_HOLDOFF) begin
            if (hold_q == '0) begin
                phase_d = PH_STOPPED;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end

        if (gnt_btn || gnt_uart) begin
            btn_ack_d   = gnt_btn;
            uart_ack_d  = gnt_uart;
            last_uart_d = gnt_uart;
            if (func == FUNC_START && (phase_q == PH_IDLE || phase_q == PH_STOPPED)) begin
                gs_en_d    = 1'b1;
                gs_func_d  = FUNC_START;
                phase_d    = PH_RUN;
                game_cnt_d = game_cnt_q + 8'd1;
            end else if (func == FUNC_END && phase_q == PH_RUN) begin
                gs_en_d   = 1'b1;
                gs_func_d = FUNC_END;
                phase_d   = PH_HOLDOFF;
                hold_d    = HOLD_LOAD;
            end else begin
                rej_d = 1'b1;
            end
        end
    end

    assign bus.btn_ack  = btn_ack_q;
    assign bus.uart_ack = uart_ack_q;
    assign bus.gs_en    = gs_en_q;
    assign bus.gs_func  = gs_func_q;
    assign bus.rej      = rej_q;
    assign bus.running  = (phase_q == PH_RUN);
    assign bus.stopped  = (phase_q == PH_STOPPED);
    assign bus.game_cnt = game_cnt_q;
    assign dbg_phase_o  = phase_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two instances (hold-off 4 and 1) share one stimulus stream
// and are checked every cycle against a phase/deadline model plus directed expectations.
module tb_game_flow_ctrl;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 1;
    localparam int P_IDLE = 0, P_RUN = 1, P_HOLD = 2, P_STOP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_req = 1'b0;
    logic [1:0] btn_func = 2'b00;
    logic       uart_req = 1'b0;
    logic [1:0] uart_func = 2'b00;
    logic [1:0] dbg_a, dbg_b;

    int tests = 0;
    int fails = 0;

    game_flow_ctrl_if bus_a ();
    game_flow_ctrl_if bus_b ();

    assign bus_a.btn_req   = btn_req;
    assign bus_a.btn_func  = btn_func;
    assign bus_a.uart_req  = uart_req;
    assign bus_a.uart_func = uart_func;
    assign bus_b.btn_req   = btn_req;
    assign bus_b.btn_func  = btn_func;
    assign bus_b.uart_req  = uart_req;
    assign bus_b.uart_func = uart_func;

    game_flow_ctrl #(.CNT_W(16), .STOP_HOLD(HOLD_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .dbg_phase_o(dbg_a)
    );
    game_flow_ctrl #(.CNT_W(16), .STOP_HOLD(HOLD_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .dbg_phase_o(dbg_b)
    );

    always #5 clk = ~clk;

    // Outputs packed as {btn_ack, uart_ack, gs_en, gs_func, rej, running, stopped, game_cnt}.
    logic [15:0] dut_vec [2];
    assign dut_vec[0] = {bus_a.btn_ack, bus_a.uart_ack, bus_a.gs_en, bus_a.gs_func,
                         bus_a.rej, bus_a.running, bus_a.stopped, bus_a.game_cnt};
    assign dut_vec[1] = {bus_b.btn_ack, bus_b.uart_ack, bus_b.gs_en, bus_b.gs_func,
                         bus_b.rej, bus_b.running, bus_b.stopped, bus_b.game_cnt};

    function automatic logic [15:0] v(bit ba, bit ua, bit en, logic [1:0] f, bit rj,
                                      bit run, bit stp, int cnt);
        return {ba, ua, en, f, rj, run, stp, 8'(cnt)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         mcyc = 0;
    bit         model_valid = 1'b0;
    int         ph [2];
    int         stop_at [2];
    bit         last_uart [2];
    bit         e_ba [2], e_ua [2], e_en [2], e_rj [2];
    logic [1:0] e_f [2];
    int         e_cnt [2];

    function automatic int hold_of(int k);
        return (k == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic void model_step(int k);
        bit         old_ack;
        int         old_ph;
        bit         w_uart;
        logic [1:0] f;
        old_ack = e_ba[k] | e_ua[k];
        old_ph  = ph[k];
        e_ba[k] = 1'b0; e_ua[k] = 1'b0; e_en[k] = 1'b0; e_rj[k] = 1'b0;
        if (rst) begin
            ph[k] = P_IDLE; last_uart[k] = 1'b1; e_f[k] = 2'b00; e_cnt[k] = 0; stop_at[k] = 0;
            return;
        end
        if (old_ph == P_HOLD) begin
            if (mcyc >= stop_at[k]) ph[k] = P_STOP;
        end else if (!old_ack && (btn_req || uart_req)) begin
            w_uart = uart_req && (!btn_req || !last_uart[k]);
            f = w_uart ? uart_func : btn_func;
            last_uart[k] = w_uart;
            e_ua[k] = w_uart;
            e_ba[k] = !w_uart;
            if (f == 2'b01 && (old_ph == P_IDLE || old_ph == P_STOP)) begin
                e_en[k] = 1'b1; e_f[k] = 2'b01; ph[k] = P_RUN;
                e_cnt[k] = (e_cnt[k] + 1) % 256;
            end else if (f == 2'b10 && old_ph == P_RUN) begin
                e_en[k] = 1'b1; e_f[k] = 2'b10; ph[k] = P_HOLD;
                stop_at[k] = mcyc + hold_of(k);
            end else begin
                e_rj[k] = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        mcyc++;
        if (rst) model_valid = 1'b1;
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++)
                check((k == 0) ? "cycle_a" : "cycle_b", dut_vec[k],
                      v(e_ba[k], e_ua[k], e_en[k], e_f[k], e_rj[k],
                        ph[k] == P_RUN, ph[k] == P_STOP, e_cnt[k]));
        end
    end

    int gsen_b = 0;
    always @(negedge clk) if (bus_b.gs_en === 1'b1) gsen_b++;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn_req = 1'b0; uart_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic raise(input bit is_uart, input logic [1:0] f);
        @(negedge clk);
        if (is_uart) begin uart_req = 1'b1; uart_func = f; end
        else begin btn_req = 1'b1; btn_func = f; end
    endtask

    task automatic drop(input bit is_uart);
        @(negedge clk);
        if (is_uart) uart_req = 1'b0;
        else btn_req = 1'b0;
    endtask

    // Counts posedges until the selected ack is seen on the selected instance.
    task automatic wait_ack(input int which, input bit is_uart, output int n);
        logic a;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (which == 0) a = is_uart ? bus_a.uart_ack : bus_a.btn_ack;
            else            a = is_uart ? bus_b.uart_ack : bus_b.btn_ack;
            if (a === 1'b1) return;
        end
        tests++; fails++;
        $display("FAIL ack_timeout: inst %0d uart %0d got no ack, required one within 100 cycles",
                 which, is_uart);
    endtask

    task automatic send(input bit is_uart, input logic [1:0] f, input int which);
        int n;
        raise(is_uart, f);
        wait_ack(which, is_uart, n);
        drop(is_uart);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int g0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", dut_vec[0], 16'h0000);
        check("reset_b", dut_vec[1], 16'h0000);

        // Start from reset: accepted one cycle after the grant, ack lasts one cycle.
        @(negedge clk);
        rst = 1'b0; btn_req = 1'b1; btn_func = 2'b01;
        wait_ack(0, 1'b0, n);
        check("start_latency", 16'(n), 16'd1);
        check("start_ack", dut_vec[0], v(1, 0, 1, 2'b01, 0, 1, 0, 1));
        drop(1'b0);
        @(posedge clk); #1;
        check("ack_one_cycle", dut_vec[0], v(0, 0, 0, 2'b01, 0, 1, 0, 1));

        // Illegal commands in IDLE are acked and rejected.
        do_reset();
        raise(1'b1, 2'b10);
        wait_ack(0, 1'b1, n);
        check("idle_end_rej", dut_vec[0], v(0, 1, 0, 2'b00, 1, 0, 0, 0));
        drop(1'b1);
        raise(1'b1, 2'b11);
        wait_ack(0, 1'b1, n);
        check("idle_11_rej", dut_vec[0], v(0, 1, 0, 2'b00, 1, 0, 0, 0));
        drop(1'b1);

        // Into RUN with btn as last grant, then both request end.
        send(1'b0, 2'b01, 0);
        @(negedge clk);
        btn_req = 1'b1; btn_func = 2'b10; uart_req = 1'b1; uart_func = 2'b10;
        wait_ack(0, 1'b1, n);
        check("rr_uart_end", dut_vec[0], v(0, 1, 1, 2'b10, 0, 0, 0, 1));
        @(negedge clk);
        uart_req = 1'b0;
        wait_ack(0, 1'b0, n);
        check("holdoff_stall_len", 16'(n), 16'(HOLD_A + 1));
        check("stopped_end_rej", dut_vec[0], v(1, 0, 0, 2'b10, 1, 0, 1, 1));
        drop(1'b0);

        // Held req: bubble cycle, then re-consumed as a new (illegal) start in RUN.
        raise(1'b1, 2'b01);
        wait_ack(0, 1'b1, n);
        check("restart", dut_vec[0], v(0, 1, 1, 2'b01, 0, 1, 0, 2));
        @(posedge clk); #1;
        check("bubble", dut_vec[0], v(0, 0, 0, 2'b01, 0, 1, 0, 2));
        @(posedge clk); #1;
        check("held_reack", dut_vec[0], v(0, 1, 0, 2'b01, 1, 1, 0, 2));
        drop(1'b1);

        // Reset during HOLDOFF with a start pending.
        send(1'b1, 2'b10, 0);
        btn_req = 1'b1; btn_func = 2'b01;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_holdoff", dut_vec[0], 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        wait_ack(0, 1'b0, n);
        check("post_rst_latency", 16'(n), 16'd1);
        check("post_rst_start", dut_vec[0], v(1, 0, 1, 2'b01, 0, 1, 0, 1));
        drop(1'b0);

        // 256 start/end rounds on the STOP_HOLD=1 instance.
        do_reset();
        @(negedge clk);
        g0 = gsen_b;
        for (int r = 0; r < 256; r++) begin
            send(1'b0, 2'b01, 1);
            send(1'b0, 2'b10, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("gs_en_512", 16'(gsen_b - g0), 16'd512);
        check("cnt_wrap", 16'(bus_b.game_cnt), 16'd0);
        check("stopped_after_loop", 16'(bus_b.stopped), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
